uart_tx_fifo_drain: RTL and testbench

Consumer end of a first-word-fall-through FIFO. The block pops bytes from the FIFO read side (data, empty, deQ) and serialises each byte as an 8N1 UART frame on a single line. It sits between the SoC-side transmit FIFO and the UART TX pin, and completes the UART path opposite the receiver that fills the RX FIFO.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_baud_tick.sv | 22 ++
 rtl/uart_tx_fifo_drain.sv | 87 ++++++++
 tb/tb_uart_tx_fifo_drain.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings and frame constants.
// Parity frames are enabled with the UART_TX_PARITY_EN macro, which widens the state to 3 bits.
package uart_pkg;
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_e;
  localparam int FRAME_BITS = 11;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_e;
  localparam int FRAME_BITS = 10;
`endif
  localparam int DEFAULT_BAUD_DIV = 434;
  localparam int DEFAULT_DIV_WIDTH = 16;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period divider shared by the UART transmitter and receiver.
// Ports: clock, reset (sync, active-high), restart (clear count), run (count enable),
//        tick (high on the last clock of each BAUD_DIV-clock bit period).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BAUD_DIV  = DEFAULT_BAUD_DIV,
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = run && cnt_q == DIV_WIDTH'(BAUD_DIV - 1);
    cnt_d = (restart || tick) ? '0 : run ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from a FWFT FIFO and sends each as a UART frame.
// Ports: clock, reset (sync, active-high), enable (allows a new frame to start),
//        fifo_data/fifo_empty (FIFO head), fifo_deQ (pop strobe, combinational),
//        tx (registered serial line, idle high), busy (frame in flight).
// Macro UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_deQ,
  output logic                  tx,
  output logic                  busy
);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_TX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif
  state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0] bit_q, bit_d;
  logic tx_q, tx_d, tick, last_bit;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  // The divider idles at zero in IDLE so every frame starts on a full bit period.
  uart_baud_tick #(.BAUD_DIV(BAUD_DIV), .DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clock   (clock),
    .reset   (reset),
    .restart (state_q == IDLE),
    .run     (state_q != IDLE),
    .tick    (tick)
  );
  always_comb begin
    fifo_deQ = state_q == IDLE && enable && !fifo_empty && !reset;
    last_bit = bit_q == BW'(DATA_WIDTH - 1);
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    if (fifo_deQ) begin
      state_d = START;
      shift_d = fifo_data;
    end else if (tick) begin
      if (state_q == DATA) begin
        shift_d = shift_q >> 1;
        bit_d   = last_bit ? '0 : bit_q + 1'b1;
      end
      state_d = state_q == START ? DATA
              : state_q == DATA  ? (last_bit ? AFTER_DATA : DATA)
              : state_q == STOP  ? IDLE : STOP;
    end
`ifdef UART_TX_PARITY_EN
    par_d = fifo_deQ ? ^fifo_data : par_q;
    tx_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
`else
    tx_d  = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  // tx is computed from the next state so the line is registered yet aligned with state_q.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock) par_q <= reset ? 1'b0 : par_d;
`endif
  assign tx   = tx_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: self-checking bench with a FIFO model and frame-level reference.
module tb_uart_tx_fifo_drain;
  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
    logic       par;
  } vec_t;
  logic clk = 1'b0;
  logic reset, enable, fifo_empty, fifo_deQ, tx, busy;
  logic [7:0] fifo_data;
  logic [7:0] q[$];
  logic exp_q[$];
  logic txlog[$];
  logic busylog[$];
  int pops, n_chk, n_pass;
  bit cur_busy;
  vec_t vecs[7];
  always #5 clk = ~clk;
  uart_tx_fifo_drain #(.DATA_WIDTH(8), .BAUD_DIV(BD), .DIV_WIDTH(16)) dut (
    .clock(clk), .reset(reset), .enable(enable), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_deQ(fifo_deQ), .tx(tx), .busy(busy)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic refresh();
    fifo_empty = q.size() == 0;
    fifo_data  = q.size() != 0 ? q[0] : 8'h00;
  endtask
  task automatic put(logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask
  task automatic push_frame(logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    bits.push_back(^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < BD; k++) exp_q.push_back(bits[i]);
  endtask
  task automatic step();
    logic pop, e;
    logic [7:0] b;
    #1;
    chk("deQ", {31'd0, fifo_deQ}, {31'd0, !cur_busy && enable && !fifo_empty && !reset});
    pop = fifo_deQ;
    b   = fifo_data;
    @(posedge clk);
    #1;
    if (reset) exp_q.delete();
    else if (pop) begin
      push_frame(b);
      pops++;
      if (q.size() != 0) q.delete(0);
    end
    cur_busy = exp_q.size() != 0;
    e = cur_busy ? exp_q.pop_front() : 1'b1;
    chk("tx", {31'd0, tx}, {31'd0, e});
    chk("busy", {31'd0, busy}, {31'd0, cur_busy});
    if (cur_busy) txlog.push_back(tx);
    busylog.push_back(busy);
    refresh();
  endtask
  task automatic wait_pop(int limit);
    int p0 = pops;
    for (int n = 0; n < limit && pops == p0; n++) step();
    chk("pop_seen", {31'd0, pops != p0}, 32'd1);
  endtask
  task automatic wait_idle(int limit);
    for (int n = 0; n < limit && cur_busy; n++) step();
    chk("frame_done", {31'd0, cur_busy}, 32'd0);
  endtask
  function automatic logic exp_bit(vec_t v, int i);
`ifdef UART_TX_PARITY_EN
    return i < 9 ? v.frame[i] : i == 9 ? v.par : v.frame[9];
`else
    return v.frame[i];
`endif
  endfunction
  task automatic frame_check(vec_t v);
    txlog.delete();
    wait_pop(20);
    wait_idle(FB * BD + 10);
    chk("frame_len", txlog.size(), FB * BD);
    for (int i = 0; i < FB; i++)
      chk($sformatf("bit%0d_of_%h", i, v.data),
          {31'd0, txlog.size() > i * BD + BD / 2 ? txlog[i * BD + BD / 2] : 1'bx}, {31'd0, exp_bit(v, i)});
  endtask
  initial begin
    int p0, first, last, gap;
    vecs[0] = '{8'h55, 10'b1_0101_0101_0, 1'b0};
    vecs[1] = '{8'hA5, 10'b1_1010_0101_0, 1'b0};
    vecs[2] = '{8'h3C, 10'b1_0011_1100_0, 1'b0};
    vecs[3] = '{8'h07, 10'b1_0000_0111_0, 1'b1};
    vecs[4] = '{8'h03, 10'b1_0000_0011_0, 1'b0};
    vecs[5] = '{8'h81, 10'b1_1000_0001_0, 1'b0};
    vecs[6] = '{8'h42, 10'b1_0100_0010_0, 1'b0};
    reset = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
    step(); step();
    reset = 1'b0;
    step();
    enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      put(vecs[i].data);
      frame_check(vecs[i]);
      step();
    end
    p0 = pops;
    for (int i = 0; i < 100; i++) step();
    chk("empty_no_pop", pops - p0, 0);
    p0 = pops;
    busylog.delete();
    put(8'hA5); put(8'h3C);
    wait_pop(20);
    for (int n = 0; n < 200 && (pops - p0 < 2 || cur_busy); n++) step();
    chk("b2b_pops", pops - p0, 2);
    first = -1; last = -1; gap = 0;
    foreach (busylog[i]) if (busylog[i]) begin if (first < 0) first = i; last = i; end
    for (int i = first; i <= last && first >= 0; i++) if (!busylog[i]) gap++;
    chk("b2b_idle_gap", gap, 1);
    p0 = pops;
    put(8'hFF); put(8'h5A);
    wait_pop(20);
    for (int i = 0; i < 13; i++) step();
    reset = 1'b1;
    step();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    frame_check('{8'h5A, 10'b1_0101_1010_0, 1'b0});
    chk("reset_pops", pops - p0, 2);
    chk("reset_fifo_left", q.size(), 0);
    p0 = pops;
    put(8'h81); put(8'h42);
    wait_pop(20);
    step();
    enable = 1'b0;
    for (int i = 0; i < 60; i++) step();
    chk("en_low_pops", pops - p0, 1);
    chk("en_low_queued", q.size(), 1);
    enable = 1'b1;
    frame_check(vecs[6]);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3 && q.size() < 4) put(8'($urandom));
      enable = $urandom_range(0, 7) != 0;
      reset  = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 1'b0; enable = 1'b1;
    for (int n = 0; n < 400 && (q.size() != 0 || cur_busy); n++) step();
    chk("drain_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
